cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_multicycle.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_cpu_multicycle.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: four-state multicycle core for the RV32I OP / OP-IMM / LUI subset.
// One instruction is accepted in IDLE, its operands are read in DECODE, the ALU
// result is registered in EXECUTE, and the register file is written in WRITEBACK.
// result/zero/illegal are loaded at the end of EXECUTE, so they are already valid
// while result_valid is high in WRITEBACK, and they hold until the next WRITEBACK.
module cpu_multicycle #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            zero,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int RIDX = $clog2(REG_COUNT);
    localparam int SHW  = $clog2(XLEN);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXECUTE,
        WRITEBACK
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_op_e;

    state_e          state_q;
    state_e          state_d;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] regs [REG_COUNT];

    // Decode-stage signals
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic signed [11:0] imm_i;
    logic signed [31:0] imm_u;
    logic [XLEN-1:0] imm_i_ext;
    logic [XLEN-1:0] imm_u_ext;
    logic [XLEN-1:0] dec_imm;
    alu_op_e         dec_op;
    logic            dec_bad;
    logic            dec_wen;
    logic            use_rs1;
    logic            use_rs2;
    logic            b_is_imm;

    // Operands captured at the end of DECODE
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    alu_op_e         alu_op_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic            bad_q;

    // ALU and architectural outputs
    logic [XLEN-1:0] alu_out;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;

    // Register read with x0 and out-of-range indices forced to zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= REG_COUNT) begin
            return '0;
        end
        return regs[idx[RIDX-1:0]];
    endfunction

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) assignments so every flop
    // samples the pre-edge value of every other flop, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake/completion strobes.
    // NOTE: every output of this block gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = WRITEBACK;
            WRITEBACK: begin
                // A reset landing in WRITEBACK aborts the instruction, so the
                // completion pulse is suppressed in that same cycle.
                result_valid = !rst;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the instruction word at the handshake; ignored in every other state.
    // NOTE: pure datapath registers carry no reset; control state guarantees they
    // are written before they are consumed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            instr_q <= in;
        end
    end

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign funct3    = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign funct7    = instr_q[31:25];
    assign imm_i     = instr_q[31:20];
    assign imm_u     = {instr_q[31:12], 12'b0};
    assign imm_i_ext = XLEN'(imm_i);
    assign imm_u_ext = XLEN'(imm_u);

    // Instruction decode: ALU operation, operand sources, write enable, legality.
    always_comb begin
        dec_op   = ALU_ADD;
        dec_bad  = 1'b0;
        dec_wen  = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        b_is_imm = 1'b0;
        dec_imm  = imm_i_ext;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_wen = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_op = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_op = ALU_SUB;
                    {F7_BASE, 3'b001}: dec_op = ALU_SLL;
                    {F7_BASE, 3'b010}: dec_op = ALU_SLT;
                    {F7_BASE, 3'b011}: dec_op = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec_op = ALU_XOR;
                    {F7_BASE, 3'b101}: dec_op = ALU_SRL;
                    {F7_ALT,  3'b101}: dec_op = ALU_SRA;
                    {F7_BASE, 3'b110}: dec_op = ALU_OR;
                    {F7_BASE, 3'b111}: dec_op = ALU_AND;
                    default:           dec_bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1  = 1'b1;
                dec_wen  = 1'b1;
                b_is_imm = 1'b1;
                case (funct3)
                    3'b000:  dec_op = ALU_ADD;
                    3'b010:  dec_op = ALU_SLT;
                    3'b011:  dec_op = ALU_SLTU;
                    3'b100:  dec_op = ALU_XOR;
                    3'b110:  dec_op = ALU_OR;
                    3'b111:  dec_op = ALU_AND;
                    default: dec_bad = 1'b1; // immediate shifts are not in this subset
                endcase
            end
            OPC_LUI: begin
                // rs1 is unused, so operand A reads as zero and ADD passes the immediate.
                dec_wen  = 1'b1;
                b_is_imm = 1'b1;
                dec_imm  = imm_u_ext;
            end
            default: dec_bad = 1'b1;
        endcase
        if ((use_rs1 && int'(rs1) >= REG_COUNT) ||
            (use_rs2 && int'(rs2) >= REG_COUNT) ||
            (dec_wen && int'(rd)  >= REG_COUNT)) begin
            dec_bad = 1'b1;
        end
        if (dec_bad) begin
            dec_wen = 1'b0;
        end
    end

    // DECODE: register operands, operation and write-back control.
    always_ff @(posedge clk) begin
        if (state_q == DECODE) begin
            op_a_q   <= use_rs1 ? rf_read(rs1) : '0;
            op_b_q   <= b_is_imm ? dec_imm : rf_read(rs2);
            alu_op_q <= dec_op;
            rd_q     <= rd;
            wen_q    <= dec_wen;
            bad_q    <= dec_bad;
        end
    end

    assign shamt = op_b_q[SHW-1:0];

    // ALU: wrapping arithmetic, logic, comparisons and shifts.
    always_comb begin
        alu_out = '0;
        case (alu_op_q)
            ALU_ADD:  alu_out = op_a_q + op_b_q;
            ALU_SUB:  alu_out = op_a_q - op_b_q;
            ALU_AND:  alu_out = op_a_q & op_b_q;
            ALU_OR:   alu_out = op_a_q | op_b_q;
            ALU_XOR:  alu_out = op_a_q ^ op_b_q;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op_a_q < op_b_q)};
            ALU_SLL:  alu_out = op_a_q << shamt;
            ALU_SRL:  alu_out = op_a_q >> shamt;
            ALU_SRA:  alu_out = $signed(op_a_q) >>> shamt;
            default:  alu_out = '0;
        endcase
    end

    // EXECUTE: register the ALU output as the visible result; illegal forces zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else if (state_q == EXECUTE) begin
            result_q  <= bad_q ? '0 : alu_out;
            zero_q    <= bad_q || (alu_out == '0);
            illegal_q <= bad_q;
        end
    end

    // WRITEBACK: commit to the register file; rd=0 is discarded.
    // NOTE: the register file is reset here because architectural registers must
    // read 0 after reset; that costs a reset net per bit rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (state_q == WRITEBACK && wen_q && rd_q != 5'd0) begin
            regs[rd_q[RIDX-1:0]] <= result_q;
        end
    end

    // Debug read port, combinational.
    always_comb begin
        dbg_data = rf_read(dbg_addr);
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed and randomized checks of cpu_multicycle against an
// ISA-level reference model (architectural register array + instruction semantics).
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_w = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] result;
    logic        result_valid;
    logic        zero;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    logic [31:0] in16 = '0;
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [31:0] result16;
    logic        result_valid16;
    logic        zero16;
    logic        illegal16;
    logic [4:0]  dbg_addr16 = '0;
    logic [31:0] dbg_data16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mregs [32];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    cpu_multicycle #(.XLEN(32), .REG_COUNT(32)) u_dut (
        .clk(clk), .rst(rst), .in(in_w), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .result_valid(result_valid), .zero(zero), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    cpu_multicycle #(.XLEN(32), .REG_COUNT(16)) u_dut16 (
        .clk(clk), .rst(rst), .in(in16), .in_valid(in_valid16), .in_ready(in_ready16),
        .result(result16), .result_valid(result_valid16), .zero(zero16), .illegal(illegal16),
        .dbg_addr(dbg_addr16), .dbg_data(dbg_data16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural semantics of the supported subset on the model register file.
    function automatic void ref_exec(input logic [31:0] w, output logic [31:0] res,
                                     output bit ill);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  sh;
        a   = mregs[w[19:15]];
        b   = mregs[w[24:20]];
        imm = {{20{w[31]}}, w[31:20]};
        sh  = b[4:0];
        ill = 1'b0;
        res = '0;
        case (w[6:0])
            7'h33: case ({w[31:25], w[14:12]})
                10'h000: res = a + b;
                10'h100: res = a - b;
                10'h001: res = a << sh;
                10'h002: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                10'h003: res = (a < b) ? 32'd1 : 32'd0;
                10'h004: res = a ^ b;
                10'h005: res = a >> sh;
                10'h105: res = $signed(a) >>> sh;
                10'h006: res = a | b;
                10'h007: res = a & b;
                default: ill = 1'b1;
            endcase
            7'h13: case (w[14:12])
                3'd0:    res = a + imm;
                3'd2:    res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
                3'd3:    res = (a < imm) ? 32'd1 : 32'd0;
                3'd4:    res = a ^ imm;
                3'd6:    res = a | imm;
                3'd7:    res = a & imm;
                default: ill = 1'b1;
            endcase
            7'h37: res = {w[31:12], 12'b0};
            default: ill = 1'b1;
        endcase
        if (ill) res = '0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [9:0]  f;
        logic [2:0]  f3;
        int          k;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        k   = $urandom_range(0, 11);
        if (k < 5) begin
            case ($urandom_range(0, 9))
                0: f = 10'h000;  1: f = 10'h100;  2: f = 10'h001;  3: f = 10'h002;
                4: f = 10'h003;  5: f = 10'h004;  6: f = 10'h005;  7: f = 10'h105;
                8: f = 10'h006;  default: f = 10'h007;
            endcase
            return {f[9:3], rs2, rs1, f[2:0], rd, 7'h33};
        end else if (k < 9) begin
            case ($urandom_range(0, 5))
                0: f3 = 3'd0;  1: f3 = 3'd2;  2: f3 = 3'd3;
                3: f3 = 3'd4;  4: f3 = 3'd6;  default: f3 = 3'd7;
            endcase
            return {12'($urandom), rs1, f3, rd, 7'h13};
        end else if (k == 9) begin
            return {20'($urandom), rd, 7'h37};
        end else if (k == 10) begin
            return {7'h00, rs2, rs1, 3'b001, rd, 7'h13};
        end
        return $urandom;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid16 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        last_res = '0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", result, 32'h0);
        check("rst_zero", zero, 1'b1);
        check("rst_illegal", illegal, 1'b0);
        check("rst_result_valid", result_valid, 1'b0);
    endtask

    // Issue one instruction on the main core and check the full 4-cycle window.
    task automatic run_instr(input logic [31:0] w, input bit junk);
        logic [31:0] er;
        bit          ei;
        int          pulses;
        ref_exec(w, er, ei);
        @(negedge clk);
        check("ready_before", in_ready, 1'b1);
        in_w = w;
        in_valid = 1'b1;
        pulses = 0;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 3 && junk) begin
                in_w = $urandom;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            pulses += int'(result_valid);
            if (k < 3) begin
                check("busy_not_ready", in_ready, 1'b0);
                check("result_hold", result, last_res);
            end else if (k == 3) begin
                check("wb_valid", result_valid, 1'b1);
                check("wb_result", result, er);
                check("wb_zero", zero, er == 32'h0);
                check("wb_illegal", illegal, ei);
                if (!ei && w[11:7] != 5'd0) mregs[w[11:7]] = er;
                last_res = er;
            end else begin
                check("ready_after", in_ready, 1'b1);
                dbg_addr = w[11:7];
                #1;
                check("dbg_rd", dbg_data, mregs[w[11:7]]);
            end
        end
        check("one_pulse", pulses, 1);
    endtask

    // Issue one instruction on the REG_COUNT=16 core and check its completion.
    task automatic run16(input logic [31:0] w, input logic [31:0] er, input bit ei);
        @(negedge clk);
        in16 = w;
        in_valid16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("r16_valid", result_valid16, 1'b1);
        check("r16_result", result16, er);
        check("r16_zero", zero16, er == 32'h0);
        check("r16_illegal", illegal16, ei);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        do_reset();

        // Directed sequence from the reference program.
        run_instr(32'h00500093, 1'b0);   // ADDI x1,x0,5
        run_instr(32'h40108133, 1'b0);   // SUB x2,x1,x1
        run_instr(32'hFFF00193, 1'b0);   // ADDI x3,x0,-1
        run_instr(32'h00700013, 1'b1);   // ADDI x0,x0,7 with busy-time junk
        run_instr(32'h0000007F, 1'b1);   // unsupported opcode
        run_instr(32'h4031D213, 1'b0);   // SRAI: unsupported immediate shift
        run_instr(32'h4011D233, 1'b0);   // SRA x4,x3,x1
        run_instr(32'h0011A2B3, 1'b0);   // SLT x5,x3,x1
        run_instr(32'h0011B333, 1'b0);   // SLTU x6,x3,x1
        run_instr(32'h800003B7, 1'b0);   // LUI x7,0x80000

        // Reset during EXECUTE aborts the instruction.
        dbg_addr = 5'd1;
        #1;
        check("x1_before_abort", dbg_data, 32'd5);
        @(negedge clk);
        in_w = 32'h00A00093;             // ADDI x1,x0,10
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_no_valid_exec", result_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        last_res = '0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_x1", dbg_data, 32'h0);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(result_valid);
        end
        check("abort_no_pulse", pulses, 0);

        // Reset and handshake in the same cycle: the instruction is dropped.
        @(negedge clk);
        rst = 1'b1;
        in_w = 32'h00900213;             // ADDI x4,x0,9
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(result_valid);
        end
        check("drop_no_pulse", pulses, 0);
        dbg_addr = 5'd4;
        #1;
        check("drop_x4", dbg_data, 32'h0);

        // Randomized instruction stream against the model.
        for (int i = 0; i < 80; i++) begin
            run_instr(rand_instr(), i[0]);
        end
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            dbg_addr = 5'(r);
            #1;
            check("final_regs", dbg_data, mregs[r]);
        end

        // Sixteen-register configuration.
        do_reset();
        run16(32'h00100A13, 32'h0, 1'b1);   // ADDI x20,x0,1: rd out of range
        run16(32'h00900293, 32'd9, 1'b0);   // ADDI x5,x0,9
        dbg_addr16 = 5'd5;
        #1;
        check("r16_x5", dbg_data16, 32'd9);
        run16(32'h011281B3, 32'h0, 1'b1);   // ADD x3,x5,x17: rs2 out of range
        run16(32'h00528333, 32'd18, 1'b0);  // ADD x6,x5,x5
        dbg_addr16 = 5'd6;
        #1;
        check("r16_x6", dbg_data16, 32'd18);
        dbg_addr16 = 5'd3;
        #1;
        check("r16_x3_untouched", dbg_data16, 32'h0);
        dbg_addr16 = 5'd20;
        #1;
        check("r16_dbg_oob", dbg_data16, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
